// File: rtl/row_buff_pkg.sv
// row_buff_pkg: shared state type, address-width helper and one-hot decoder for row_buffer_ctrl
package row_buff_pkg;

    typedef enum logic [1:0] {EMPTY, OPEN, ACT, FILL} state_t;

    // Widest one-hot field the decoder accepts
    localparam int OH_MAX = 64;

    typedef struct packed {
        logic       ok;
        logic [7:0] idx;
    } oh_t;

    function automatic int addr_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    function automatic oh_t oh2bin(input logic [OH_MAX-1:0] v);
        oh_t r;
        r = '0;
        for (int i = 0; i < OH_MAX; i++)
            if (v[i]) r.idx = r.idx | 8'(i);
        r.ok = v != '0 && (v & (v - OH_MAX'(1))) == '0;
        return r;
    endfunction

endpackage

// File: rtl/row_word_sel.sv
// row_word_sel: word and bit select from one row, zeroed with err on out-of-range column or bit
module row_word_sel
    import row_buff_pkg::*;
#(
    parameter int WORD_W   = 8,
    parameter int NUM_COLS = 8,
    localparam int CA_W = addr_w(NUM_COLS),
    localparam int BA_W = addr_w(WORD_W)
) (
    input  logic [NUM_COLS*WORD_W-1:0] row,
    input  logic [CA_W-1:0]            col,
    input  logic [BA_W-1:0]            bsel,
    output logic [WORD_W-1:0]          word,
    output logic                       bval,
    output logic                       err
);

    logic [WORD_W-1:0] w;

    always_comb begin
        w = '0;
        for (int c = 0; c < NUM_COLS; c++)
            if (col == CA_W'(c)) w = row[c*WORD_W +: WORD_W];
        err = 32'(col) >= NUM_COLS || 32'(bsel) >= WORD_W;
        word = err ? '0 : w;
        bval = 1'b0;
        for (int b = 0; b < WORD_W; b++)
            if (bsel == BA_W'(b)) bval = word[b];
    end

endmodule

// File: rtl/row_buffer_ctrl.sv
// row_buffer_ctrl: one open row in front of a row array, fetched on miss, with hit/miss counters.
// ROW_BUFF_ONEHOT_EN: one-hot request fields; non-one-hot requests answer with rsp_err and no side effects.
module row_buffer_ctrl
    import row_buff_pkg::*;
#(
    parameter int WORD_W   = 8,
    parameter int NUM_COLS = 8,
    parameter int NUM_ROWS = 8,
    parameter int CNT_W    = 16,
    localparam int RA_W = addr_w(NUM_ROWS),
    localparam int CA_W = addr_w(NUM_COLS),
    localparam int BA_W = addr_w(WORD_W),
`ifdef ROW_BUFF_ONEHOT_EN
    localparam int RI_W = NUM_ROWS,
    localparam int CI_W = NUM_COLS,
    localparam int BI_W = WORD_W
`else
    localparam int RI_W = RA_W,
    localparam int CI_W = CA_W,
    localparam int BI_W = BA_W
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [RI_W-1:0]            req_row,
    input  logic [CI_W-1:0]            req_col,
    input  logic [BI_W-1:0]            req_bit,
    output logic                       rsp_valid,
    output logic [WORD_W-1:0]          rsp_word,
    output logic                       rsp_bit,
    output logic                       rsp_hit,
    output logic                       rsp_err,
    input  logic                       close,
    output logic                       arr_req_valid,
    input  logic                       arr_req_ready,
    output logic [RA_W-1:0]            arr_req_row,
    input  logic                       arr_fill_valid,
    input  logic [NUM_COLS*WORD_W-1:0] arr_fill_data,
    output logic                       open_valid,
    output logic [RA_W-1:0]            open_row,
    output logic [CNT_W-1:0]           hit_cnt,
    output logic [CNT_W-1:0]           miss_cnt
);

    state_t                     state;
    logic [NUM_COLS*WORD_W-1:0] row_q;
    logic [CA_W-1:0]            lat_col;
    logic [BA_W-1:0]            lat_bit;
    logic                       pend_close, rdy_q;
    logic [RA_W-1:0]            r_row;
    logic [CA_W-1:0]            r_col;
    logic [BA_W-1:0]            r_bit;
    logic                       r_bad, accept, hit, filling, closing;
    logic [WORD_W-1:0]          sel_word;
    logic                       sel_bit, sel_err;

`ifdef ROW_BUFF_ONEHOT_EN
    oh_t oh_r, oh_c, oh_b;

    always_comb begin
        oh_r  = oh2bin(OH_MAX'(req_row));
        oh_c  = oh2bin(OH_MAX'(req_col));
        oh_b  = oh2bin(OH_MAX'(req_bit));
        r_row = RA_W'(oh_r.idx);
        r_col = CA_W'(oh_c.idx);
        r_bit = BA_W'(oh_b.idx);
        r_bad = !(oh_r.ok && oh_c.ok && oh_b.ok);
    end
`else
    assign r_row = req_row;
    assign r_col = req_col;
    assign r_bit = req_bit;
    assign r_bad = 1'b0;
`endif

    assign req_ready = rdy_q && !close;
    assign accept    = req_valid && req_ready;
    assign hit       = state == OPEN && r_row == open_row;
    assign filling   = state == FILL && arr_fill_valid;
    assign closing   = pend_close || close;

    // On the fill cycle the select reads the incoming row with the latched column/bit
    row_word_sel #(.WORD_W(WORD_W), .NUM_COLS(NUM_COLS)) u_sel (
        .row  (filling ? arr_fill_data : row_q),
        .col  (filling ? lat_col : r_col),
        .bsel (filling ? lat_bit : r_bit),
        .word (sel_word),
        .bval (sel_bit),
        .err  (sel_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= EMPTY;
            row_q         <= '0;
            lat_col       <= '0;
            lat_bit       <= '0;
            pend_close    <= 1'b0;
            rdy_q         <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_word      <= '0;
            rsp_bit       <= 1'b0;
            rsp_hit       <= 1'b0;
            rsp_err       <= 1'b0;
            arr_req_valid <= 1'b0;
            arr_req_row   <= '0;
            open_valid    <= 1'b0;
            open_row      <= '0;
            hit_cnt       <= '0;
            miss_cnt      <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                EMPTY, OPEN: begin
                    rdy_q <= 1'b1;
                    if (close) begin
                        state      <= EMPTY;
                        open_valid <= 1'b0;
                    end else if (accept && (r_bad || hit)) begin
                        rsp_valid <= 1'b1;
                        rsp_hit   <= !r_bad;
                        rsp_word  <= r_bad ? '0 : sel_word;
                        rsp_bit   <= !r_bad && sel_bit;
                        rsp_err   <= r_bad || sel_err;
                        if (!r_bad && hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
                    end else if (accept) begin
                        state         <= ACT;
                        rdy_q         <= 1'b0;
                        open_valid    <= 1'b0;
                        arr_req_valid <= 1'b1;
                        arr_req_row   <= r_row;
                        lat_col       <= r_col;
                        lat_bit       <= r_bit;
                    end
                end
                ACT: begin
                    pend_close <= closing;
                    if (arr_req_ready) begin
                        state         <= FILL;
                        arr_req_valid <= 1'b0;
                    end
                end
                FILL: begin
                    pend_close <= closing;
                    if (arr_fill_valid) begin
                        state      <= closing ? EMPTY : OPEN;
                        open_valid <= !closing;
                        pend_close <= 1'b0;
                        rdy_q      <= 1'b1;
                        row_q      <= arr_fill_data;
                        open_row   <= arr_req_row;
                        rsp_valid  <= 1'b1;
                        rsp_hit    <= 1'b0;
                        rsp_word   <= sel_word;
                        rsp_bit    <= sel_bit;
                        rsp_err    <= sel_err;
                        if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_row_buffer_ctrl.sv
// tb_row_buffer_ctrl: scoreboard bench for row_buffer_ctrl plus a 2-bit-counter instance for saturation
module tb_row_buffer_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, close = 1'b0;
    logic [2:0]  req_row = '0, req_col = '0, req_bit = '0;
    logic        req_ready, rsp_valid, rsp_bit, rsp_hit, rsp_err, arr_req_valid, open_valid;
    logic [7:0]  rsp_word;
    logic [2:0]  arr_req_row, open_row;
    logic        arr_req_ready = 1'b0, arr_fill_valid = 1'b0;
    logic [63:0] arr_fill_data = '0;
    logic [15:0] hit_cnt, miss_cnt;

    logic        s_req_valid = 1'b0, s_close = 1'b0, s_arr_ready = 1'b1, s_fill_valid = 1'b1;
    logic [2:0]  s_req_row = 3'd2, s_req_col = 3'd4, s_req_bit = 3'd2;
    logic [63:0] s_fill_data;
    logic        s_req_ready, s_rsp_valid, s_rsp_bit, s_rsp_hit, s_rsp_err, s_arr_req_valid, s_open_valid;
    logic [7:0]  s_rsp_word;
    logic [2:0]  s_arr_req_row, s_open_row;
    logic [1:0]  s_hit_cnt, s_miss_cnt;

    row_buffer_ctrl u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_row(req_row), .req_col(req_col), .req_bit(req_bit),
        .rsp_valid(rsp_valid), .rsp_word(rsp_word), .rsp_bit(rsp_bit), .rsp_hit(rsp_hit), .rsp_err(rsp_err),
        .close(close), .arr_req_valid(arr_req_valid), .arr_req_ready(arr_req_ready), .arr_req_row(arr_req_row),
        .arr_fill_valid(arr_fill_valid), .arr_fill_data(arr_fill_data),
        .open_valid(open_valid), .open_row(open_row), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    row_buffer_ctrl #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_ready(s_req_ready),
        .req_row(s_req_row), .req_col(s_req_col), .req_bit(s_req_bit),
        .rsp_valid(s_rsp_valid), .rsp_word(s_rsp_word), .rsp_bit(s_rsp_bit), .rsp_hit(s_rsp_hit), .rsp_err(s_rsp_err),
        .close(s_close), .arr_req_valid(s_arr_req_valid), .arr_req_ready(s_arr_ready), .arr_req_row(s_arr_req_row),
        .arr_fill_valid(s_fill_valid), .arr_fill_data(s_fill_data),
        .open_valid(s_open_valid), .open_row(s_open_row), .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
    );

    typedef struct {
        logic [7:0] word;
        logic       bitv;
        logic       hit;
        int         due;
    } exp_t;

    exp_t       q[$];
    exp_t       e_mon;
    int         checks = 0, failures = 0, cyc = 0;
    int         exp_hits = 0, exp_miss = 0;
    logic       m_valid = 1'b0;
    logic [2:0] m_row = '0, fetch_row = '0;

    int         ready_delay = 0, fill_delay = 0, rcnt = 0, fcnt = 0;
    logic       fetching = 1'b0, inj_fill = 1'b0;
    logic [2:0] frow = '0;

    function automatic logic [7:0] word_of(input int r, input int c);
        return {4'(r), 4'(c)};
    endfunction

    function automatic logic [63:0] row_data(input int r);
        logic [63:0] d;
        for (int c = 0; c < 8; c++) d[c*8 +: 8] = word_of(r, c);
        return d;
    endfunction

    assign s_fill_data = row_data(2);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Array model: ready after ready_delay ACT cycles, one fill beat fill_delay cycles later
    initial forever begin
        @(negedge clk);
        arr_fill_valid = inj_fill;
        arr_req_ready  = 1'b0;
        if (inj_fill) arr_fill_data = row_data(3);
        if (rst) begin
            fetching = 1'b0;
            rcnt     = 0;
        end else if (fetching) begin
            if (fcnt == 0) begin
                arr_fill_valid = 1'b1;
                arr_fill_data  = row_data(frow);
                fetching       = 1'b0;
            end else fcnt--;
        end else if (arr_req_valid) begin
            if (rcnt >= ready_delay) begin
                arr_req_ready = 1'b1;
                fetching      = 1'b1;
                frow          = arr_req_row;
                fcnt          = fill_delay;
                rcnt          = 0;
            end else rcnt++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rsp_valid) begin
            if (q.size() == 0) check("spurious_rsp", 1, 0);
            else begin
                e_mon = q.pop_front();
                check("rsp_word", rsp_word, e_mon.word);
                check("rsp_bit", rsp_bit, e_mon.bitv);
                check("rsp_hit", rsp_hit, e_mon.hit);
                check("rsp_err", rsp_err, 0);
                if (e_mon.due >= 0) check("rsp_latency", cyc, e_mon.due);
            end
        end
        if (arr_req_valid) begin
            check("arr_req_row", arr_req_row, fetch_row);
            check("ready_in_act", req_ready, 0);
        end
    end

    task automatic send(input int r, input int c, input int b, input int lat);
        exp_t e;
        int   n = 0;
        req_valid = 1'b1;
        req_row   = 3'(r);
        req_col   = 3'(c);
        req_bit   = 3'(b);
        #1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("accepted", req_ready, 1);
        if (req_ready) begin
            e.word = word_of(r, c);
            e.bitv = e.word[b];
            e.hit  = m_valid && m_row == 3'(r);
            e.due  = lat < 0 ? -1 : cyc + lat;
            if (e.hit) exp_hits++;
            else begin
                exp_miss++;
                fetch_row = 3'(r);
            end
            m_valid = 1'b1;
            m_row   = 3'(r);
            q.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", q.size(), 0);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs", {req_ready, rsp_valid, rsp_word, rsp_bit, rsp_hit, rsp_err, arr_req_valid,
                                arr_req_row, open_valid, open_row, hit_cnt, miss_cnt}, 0);
        rst = 1'b0;
        @(negedge clk);

        send(3, 5, 0, 3);
        drain();
        check("cold_miss_cnt", miss_cnt, exp_miss);
        check("cold_open_row", {open_valid, open_row}, {1'b1, 3'd3});

        send(3, 0, 4, 1);
        send(3, 7, 0, 1);
        send(3, 2, 1, 1);
        drain();
        check("hit_cnt_3", hit_cnt, 3);

        ready_delay = 4;
        fill_delay  = 2;
        send(6, 1, 0, -1);
        drain();
        check("switch_open_row", {open_valid, open_row}, {1'b1, 3'd6});
        check("switch_miss_cnt", miss_cnt, exp_miss);
        ready_delay = 0;
        fill_delay  = 0;

        req_valid = 1'b1;
        close     = 1'b1;
        req_row   = 3'd6;
        req_col   = 3'd2;
        #1 check("close_blocks_req", req_ready, 0);
        @(negedge clk);
        #1;
        close     = 1'b0;
        req_valid = 1'b0;
        check("close_open_valid", open_valid, 0);
        m_valid = 1'b0;
        send(6, 2, 3, 3);
        drain();
        check("close_retry_miss", miss_cnt, exp_miss);

        fill_delay = 3;
        send(1, 4, 2, -1);
        @(negedge clk);
        close = 1'b1;
        @(negedge clk);
        close = 1'b0;
        drain();
        check("close_fill_empty", open_valid, 0);
        m_valid = 1'b0;
        fill_delay = 0;
        send(1, 4, 5, 3);
        drain();
        check("fill_close_counts", {hit_cnt, miss_cnt}, {16'(exp_hits), 16'(exp_miss)});

        ready_delay = 100;
        req_valid   = 1'b1;
        req_row     = 3'd5;
        req_col     = 3'd0;
        req_bit     = 3'd0;
        fetch_row   = 3'd5;
        #1 check("rst_act_accept", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        #1 check("act_req_valid", arr_req_valid, 1);
        #2 rst = 1'b1;
        #1 check("rst_async_drop", arr_req_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        ready_delay = 0;
        exp_hits = 0;
        exp_miss = 0;
        m_valid  = 1'b0;
        #1 inj_fill = 1'b1;
        @(negedge clk);
        #1 inj_fill = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_quiet", {rsp_valid, rsp_word, rsp_bit, rsp_hit, rsp_err, arr_req_valid,
                                 arr_req_row, open_valid, open_row, hit_cnt, miss_cnt}, 0);
        send(2, 3, 1, 3);
        drain();
        check("post_rst_counts", {hit_cnt, miss_cnt}, {16'd0, 16'd1});

        begin
            int n = 0;
            s_req_valid = 1'b1;
            #1;
            while (!s_req_ready && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            @(negedge clk);
            s_req_valid = 1'b0;
            n = 0;
            while (!s_open_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("sat_miss_cnt", s_miss_cnt, 1);
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                s_req_valid = 1'b1;
                #1 check("sat_ready", s_req_ready, 1);
                @(negedge clk);
                s_req_valid = 1'b0;
                check("sat_rsp", {s_rsp_valid, s_rsp_hit, s_rsp_word, s_rsp_bit}, {2'b11, 8'h24, 1'b1});
                check("sat_hit_cnt", s_hit_cnt, k < 3 ? k : 3);
            end
            check("sat_miss_hold", s_miss_cnt, 1);
        end

        check("pending", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
